// File: rtl/uart_rx_checker_if.sv
// Character delivery channel of the UART receiver: data plus per-character
// error flags behind a valid/ready handshake.
interface uart_rx_checker_if #(
   parameter int unsigned DWIDTH = 8
);
   logic [DWIDTH-1:0] RX_DATA;
   logic              RX_VALID;
   logic              RX_READY;
   logic              PARITYERR;
   logic              FRAMEERR;

   modport master (
      output RX_DATA,
      output RX_VALID,
      output PARITYERR,
      output FRAMEERR,
      input  RX_READY
   );

   modport slave (
      input  RX_DATA,
      input  RX_VALID,
      input  PARITYERR,
      input  FRAMEERR,
      output RX_READY
   );
endinterface

// File: rtl/uart_rx_checker.sv
// Oversampling UART receiver with parity/stop/break checking and a one-entry
// output buffer carrying sticky overrun and break flags.
module uart_rx_checker #(
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic                BAUD_TICK,
   input  logic                RXD,
   input  logic [3:0]          CHARLEN,
   input  logic                PARITYEN,
   input  logic                PARITYSEL,
   input  logic                STICKPAR,
   input  logic                STOPBITS,
   input  logic                ERR_CLR,
   output logic                BREAKINT,
   output logic                OVERRUN,
   output logic                BUSY,
   uart_rx_checker_if.master   rx_bus
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [3:0]       MAX_LEN   = 4'(DWIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK_WAIT
   } state_t;

   state_t             r_state;
   logic               r_rxd_meta;
   logic               r_rxd_s;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_bit_cnt;
   logic [DWIDTH-1:0]  r_shift;
   logic [3:0]         r_charlen;
   logic               r_par_en;
   logic               r_par_sel;
   logic               r_stick;
   logic               r_two_stop;
   logic               r_perr;
   logic               r_ferr;
   logic               r_all_zero;
   logic               r_busy;
   logic [DWIDTH-1:0]  r_data_o;
   logic               r_valid_o;
   logic               r_perr_o;
   logic               r_ferr_o;
   logic               r_breakint;
   logic               r_overrun;

   logic [3:0]         w_charlen;
   logic               w_bit_end;
   logic               w_par_exp;
   logic               w_stop1_hit;
   logic               w_brk_hit;
   logic               w_done;
   logic               w_ovr_set;
   logic [DWIDTH-1:0]  w_aligned;

   // Out-of-range lengths fall back to the full data width
   assign w_charlen   = (CHARLEN < 4'd5 || CHARLEN > MAX_LEN) ? MAX_LEN : CHARLEN;
   assign w_bit_end   = BAUD_TICK && (r_cnt == FULL_LAST);
   assign w_par_exp   = r_stick ? r_par_sel : ((^r_shift) ^ r_par_sel);
   assign w_stop1_hit = (r_state == S_STOP1) && w_bit_end;
   assign w_brk_hit   = w_stop1_hit && r_all_zero && !r_rxd_s;
   assign w_done      = (w_stop1_hit && (!r_two_stop || w_brk_hit)) ||
                        ((r_state == S_STOP2) && w_bit_end);
   assign w_ovr_set   = w_done && r_valid_o && !rx_bus.RX_READY;
   // Bits were shifted in from the top; realign LSB to bit 0
   assign w_aligned   = r_shift >> (MAX_LEN - r_charlen);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
      end else begin
         r_rxd_meta <= RXD;
         r_rxd_s    <= r_rxd_meta;
      end
   end

   // Frame FSM; all sampling advances on BAUD_TICK only
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_charlen  <= MAX_LEN;
         r_par_en   <= 1'b0;
         r_par_sel  <= 1'b0;
         r_stick    <= 1'b0;
         r_two_stop <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_all_zero <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (BAUD_TICK && !r_rxd_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (BAUD_TICK) begin
                  if (r_cnt == HALF_LAST) begin
                     r_cnt <= '0;
                     if (!r_rxd_s) begin
                        r_state    <= S_DATA;
                        r_bit_cnt  <= '0;
                        r_shift    <= '0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_all_zero <= 1'b1;
                        r_charlen  <= w_charlen;
                        r_par_en   <= PARITYEN;
                        r_par_sel  <= PARITYSEL;
                        r_stick    <= STICKPAR;
                        r_two_stop <= STOPBITS;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
               if (BAUD_TICK && r_cnt != FULL_LAST) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_state == S_DATA) begin
                     r_shift   <= {r_rxd_s, r_shift[DWIDTH-1:1]};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_rxd_s) r_all_zero <= 1'b0;
                     if (r_bit_cnt == r_charlen - 4'd1)
                        r_state <= r_par_en ? S_PARITY : S_STOP1;
                  end else if (r_state == S_PARITY) begin
                     r_perr  <= (r_rxd_s != w_par_exp);
                     if (r_rxd_s) r_all_zero <= 1'b0;
                     r_state <= S_STOP1;
                  end else if (r_state == S_STOP1) begin
                     if (w_brk_hit) begin
                        r_state <= S_BREAK_WAIT;
                     end else if (r_two_stop) begin
                        r_ferr  <= ~r_rxd_s;
                        r_state <= S_STOP2;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_BREAK_WAIT: begin
               if (BAUD_TICK && r_rxd_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // One-entry output buffer; a full, unconsumed buffer drops the new character
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_data_o   <= '0;
         r_valid_o  <= 1'b0;
         r_perr_o   <= 1'b0;
         r_ferr_o   <= 1'b0;
         r_breakint <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_done && (!r_valid_o || rx_bus.RX_READY)) begin
            r_data_o  <= w_aligned;
            r_perr_o  <= r_perr;
            r_ferr_o  <= r_ferr | ~r_rxd_s;
            r_valid_o <= 1'b1;
         end else if (r_valid_o && rx_bus.RX_READY) begin
            r_valid_o <= 1'b0;
         end
         r_breakint <= w_brk_hit | (r_breakint & ~ERR_CLR);
         r_overrun  <= w_ovr_set | (r_overrun & ~ERR_CLR);
      end
   end

   assign rx_bus.RX_DATA   = r_data_o;
   assign rx_bus.RX_VALID  = r_valid_o;
   assign rx_bus.PARITYERR = r_perr_o;
   assign rx_bus.FRAMEERR  = r_ferr_o;
   assign BREAKINT         = r_breakint;
   assign OVERRUN          = r_overrun;
   assign BUSY             = r_busy;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Scoreboard bench for uart_rx_checker: serial frames in, expected characters
// queued per frame and compared at each RX_VALID & RX_READY handshake.
module tb_uart_rx_checker;

   localparam int unsigned DW       = 8;
   localparam int unsigned OS       = 16;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned BIT_CLKS = OS * TICK_DIV;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          perr;
      logic          ferr;
   } exp_t;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       BAUD_TICK = 1'b0;
   logic       RXD = 1'b1;
   logic [3:0] CHARLEN = 4'd8;
   logic       PARITYEN = 1'b0;
   logic       PARITYSEL = 1'b0;
   logic       STICKPAR = 1'b0;
   logic       STOPBITS = 1'b0;
   logic       ERR_CLR = 1'b0;
   logic       BREAKINT;
   logic       OVERRUN;
   logic       BUSY;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   hs_count = 0;

   uart_rx_checker_if #(.DWIDTH(DW)) rx_if ();

   uart_rx_checker #(.DWIDTH(DW), .OVERSAMPLE(OS)) u_dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .BAUD_TICK (BAUD_TICK),
      .RXD       (RXD),
      .CHARLEN   (CHARLEN),
      .PARITYEN  (PARITYEN),
      .PARITYSEL (PARITYSEL),
      .STICKPAR  (STICKPAR),
      .STOPBITS  (STOPBITS),
      .ERR_CLR   (ERR_CLR),
      .BREAKINT  (BREAKINT),
      .OVERRUN   (OVERRUN),
      .BUSY      (BUSY),
      .rx_bus    (rx_if)
   );

   initial forever #5 PCLK = ~PCLK;

   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(negedge PCLK);
         BAUD_TICK = 1'b1;
         @(negedge PCLK);
         BAUD_TICK = 1'b0;
      end
   end

   // Scoreboard: every handshake must match the oldest queued expectation
   always @(negedge PCLK) begin
      if (PRESETn && rx_if.RX_VALID && rx_if.RX_READY) begin
         exp_t e;
         hs_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_char got data=%h perr=%b ferr=%b, required none",
                     rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR);
         end else begin
            e = exp_q.pop_front();
            if ({rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR} !== e) begin
               errors++;
               $display("FAIL char got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                        rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR, e.data, e.perr, e.ferr);
            end
         end
      end
   end

   task automatic send_bit(input logic b);
      RXD = b;
      repeat (BIT_CLKS) @(negedge PCLK);
   endtask

   task automatic send_frame(input logic [8:0] data, input int nbits, input logic has_par,
                             input logic par_bit, input logic stop1, input logic has_stop2,
                             input logic stop2);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(data[i]);
      if (has_par) send_bit(par_bit);
      send_bit(stop1);
      if (has_stop2) send_bit(stop2);
      RXD = 1'b1;
   endtask

   task automatic set_cfg(input logic [3:0] cl, input logic pe, input logic ps,
                          input logic sp, input logic sb);
      CHARLEN = cl; PARITYEN = pe; PARITYSEL = ps; STICKPAR = sp; STOPBITS = sb;
   endtask

   task automatic test_reset;
      PRESETn = 1'b0;
      rx_if.RX_READY = 1'b1;
      repeat (3) @(negedge PCLK);
      checks++;
      if ({rx_if.RX_VALID, rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR, BREAKINT, OVERRUN, BUSY} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b data=%h pe=%b fe=%b brk=%b ovr=%b busy=%b, required all 0",
                  rx_if.RX_VALID, rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR, BREAKINT, OVERRUN, BUSY);
      end
      PRESETn = 1'b1;
      repeat (BIT_CLKS) @(negedge PCLK);
   endtask

   task automatic test_8n1;
      int n0 = hs_count;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      checks++;
      if (hs_count - n0 !== 1 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL 8n1_count got %0d handshakes (%0d pending), required 1", hs_count - n0, exp_q.size());
      end
   endtask

   task automatic test_parity;
      int n0 = hs_count;
      set_cfg(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0});
      send_frame(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      set_cfg(4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0});
      send_frame(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      set_cfg(4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      exp_q.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0});
      send_frame(9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      checks++;
      if (hs_count - n0 !== 3 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL parity_count got %0d handshakes (%0d pending), required 3", hs_count - n0, exp_q.size());
      end
   endtask

   task automatic test_7n2;
      int n0 = hs_count;
      set_cfg(4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
      send_frame(9'h055, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_bit(1'b1);
      exp_q.push_back('{data: 8'h2A, perr: 1'b0, ferr: 1'b0});
      send_frame(9'h02A, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_bit(1'b1);
      checks++;
      if (hs_count - n0 !== 2 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL 7n2_count got %0d handshakes (%0d pending), required 2", hs_count - n0, exp_q.size());
      end
   endtask

   task automatic test_break;
      int n0 = hs_count;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
      RXD = 1'b0;
      repeat (20 * BIT_CLKS) @(negedge PCLK);
      RXD = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge PCLK);
      checks++;
      if (hs_count - n0 !== 1 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL break_count got %0d handshakes (%0d pending), required 1", hs_count - n0, exp_q.size());
      end
      checks++;
      if (BREAKINT !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL break_flag got brk=%b busy=%b, required brk=1 busy=0", BREAKINT, BUSY);
      end
      ERR_CLR = 1'b1;
      @(negedge PCLK);
      ERR_CLR = 1'b0;
      @(negedge PCLK);
      checks++;
      if (BREAKINT !== 1'b0) begin
         errors++;
         $display("FAIL break_clear got brk=%b, required 0", BREAKINT);
      end
   endtask

   task automatic test_glitch;
      int n0 = hs_count;
      RXD = 1'b0;
      repeat (4 * TICK_DIV) @(negedge PCLK);
      RXD = 1'b1;
      checks++;
      if (BUSY !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy got busy=%b, required 1", BUSY);
      end
      repeat (BIT_CLKS) @(negedge PCLK);
      checks++;
      if (BUSY !== 1'b0 || hs_count - n0 !== 0) begin
         errors++;
         $display("FAIL glitch_idle got busy=%b handshakes=%0d, required busy=0 handshakes=0",
                  BUSY, hs_count - n0);
      end
   endtask

   task automatic test_back_to_back;
      int n0 = hs_count;
      // CHARLEN below 5 is treated as the full 8-bit width
      set_cfg(4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
      exp_q.push_back('{data: 8'hC3, perr: 1'b1, ferr: 1'b0});
      send_frame(9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(9'h0C3, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      checks++;
      if (hs_count - n0 !== 2 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_count got %0d handshakes (%0d pending), required 2", hs_count - n0, exp_q.size());
      end
   endtask

   task automatic test_overrun_reset;
      int n0;
      set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      rx_if.RX_READY = 1'b0;
      send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      checks++;
      if (rx_if.RX_VALID !== 1'b1 || rx_if.RX_DATA !== 8'h11 || OVERRUN !== 1'b1) begin
         errors++;
         $display("FAIL overrun got valid=%b data=%h ovr=%b, required valid=1 data=11 ovr=1",
                  rx_if.RX_VALID, rx_if.RX_DATA, OVERRUN);
      end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      PRESETn = 1'b0;
      @(negedge PCLK);
      checks++;
      if ({rx_if.RX_VALID, rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR, BREAKINT, OVERRUN, BUSY} !== '0) begin
         errors++;
         $display("FAIL midframe_reset got valid=%b data=%h pe=%b fe=%b brk=%b ovr=%b busy=%b, required all 0",
                  rx_if.RX_VALID, rx_if.RX_DATA, rx_if.PARITYERR, rx_if.FRAMEERR, BREAKINT, OVERRUN, BUSY);
      end
      RXD = 1'b1;
      repeat (4) @(negedge PCLK);
      PRESETn = 1'b1;
      rx_if.RX_READY = 1'b1;
      n0 = hs_count;
      repeat (12 * BIT_CLKS) @(negedge PCLK);
      checks++;
      if (hs_count - n0 !== 0 || rx_if.RX_VALID !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got handshakes=%0d valid=%b busy=%b, required 0/0/0",
                  hs_count - n0, rx_if.RX_VALID, BUSY);
      end
   endtask

   initial begin
      rx_if.RX_READY = 1'b1;
      test_reset();
      test_8n1();
      test_parity();
      test_7n2();
      test_break();
      test_glitch();
      test_back_to_back();
      test_overrun_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_checker.md
Name: uart_rx_checker

Overview:
- Parametrised UART receive engine with an integrated frame and parity checker, successor to the standalone combinational parity checker.
- Oversamples the synchronised RXD line, deserialises 5–9 bit characters and checks parity in even, odd or stick mode plus 1 or 2 stop bits.
- Presents each character with per-character PARITYERR/FRAMEERR through a one-entry valid/ready buffer, with sticky overrun and break flags.
- Sits between the pad-side RXD and the UART register/FIFO front-end.

Parameters:
- DWIDTH, 8, maximum data bits per character (5..9); RX_DATA width.
- OVERSAMPLE, 16, BAUD_TICK pulses per bit period; even, >= 4.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous active-low reset.
- BAUD_TICK  in  1  single-cycle enable, OVERSAMPLE per bit.
- RXD  in  1  asynchronous serial input, idle high.
- CHARLEN  in  4  active data bits, 5..DWIDTH; values outside that range are treated as DWIDTH.
- PARITYEN  in  1  1 = parity bit present.
- PARITYSEL  in  1  0 = even, 1 = odd; with STICKPAR=1, the value of the expected parity bit.
- STICKPAR  in  1  stick parity mode.
- STOPBITS  in  1  0 = one stop bit, 1 = two stop bits.
- RX_DATA  out  DWIDTH  received character, LSB first on the line, zero-extended above CHARLEN.
- RX_VALID  out  1  RX_DATA/PARITYERR/FRAMEERR valid.
- RX_READY  in  1  consumer accepts when RX_VALID & RX_READY.
- PARITYERR  out  1  parity mismatch for the presented character.
- FRAMEERR  out  1  stop-bit error for the presented character.
- BREAKINT  out  1  sticky break detected.
- OVERRUN  out  1  sticky, a character was lost.
- ERR_CLR  in  1  single-cycle clear of BREAKINT and OVERRUN.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchroniser flops set to 1. Reset mid-frame aborts the frame; no partial character is output.
- RXD passes through a 2-flop synchroniser (rxd_s). All decisions below use rxd_s and advance only on BAUD_TICK.
- Configuration inputs are sampled at start-bit confirmation and held for the frame. Mid-frame changes take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE -> START: on a falling rxd_s (0 sampled on a tick). Tick counter cleared.
- START: at tick OVERSAMPLE/2, rxd_s=0 -> DATA with counter cleared; rxd_s=1 -> IDLE (false start, no output).
- DATA: sample every OVERSAMPLE ticks (mid-bit) and shift LSB-first. After CHARLEN bits -> PARITY if PARITYEN, else STOP1.
- PARITY: expected bit = STICKPAR ? PARITYSEL : (^data ^ PARITYSEL). The per-character parity error is set when the sampled bit differs from the expected bit.
- STOP1: sample. STOPBITS=1 -> STOP2; otherwise complete.
- STOP2: sample, then complete. The per-character frame error is set if any sampled stop bit is 0.
- Break: data all 0, parity bit 0 (if enabled) and STOP1 sample 0. On a break:
  - Character 0 is delivered with FRAMEERR=1.
  - BREAKINT is set.
  - The FSM enters BREAK_WAIT, skipping STOP2.
- BREAK_WAIT -> IDLE on the first tick with rxd_s=1.
- Completion: the character and its flags are loaded into the output buffer and RX_VALID is set on the PCLK edge after the last stop-bit sample tick. The FSM returns to IDLE that same cycle; a start bit may follow immediately.
- Buffer: RX_DATA, PARITYERR and FRAMEERR are stable while RX_VALID=1. RX_VALID falls the cycle after RX_VALID & RX_READY.
- Overrun:
  - On completion with RX_VALID=1 and RX_READY=0, the new character is discarded, the buffer is kept and OVERRUN is set.
  - If RX_READY=1 in the completion cycle, the new character replaces the old one and no overrun is flagged.
- Sticky flags: ERR_CLR clears BREAKINT and OVERRUN. A set in the same cycle wins over ERR_CLR.
- BUSY = (state != IDLE).

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 with valid stop, RX_READY=1 -> RX_VALID pulses once, RX_DATA=0xA5, PARITYERR=0, FRAMEERR=0.
- 8E1, send 0x03 with parity bit 1 -> RX_DATA=0x03, PARITYERR=1. Repeat 8O1 with bit 1 -> PARITYERR=0. Repeat with STICKPAR=1, PARITYSEL=1, bit 0 -> PARITYERR=1.
- 7N2, send 0x55 with second stop bit 0 -> RX_DATA=0x55, FRAMEERR=1. Then 0x2A with good stops -> FRAMEERR=0.
- RXD low for 2 full frame times, then high -> one character 0x00 with FRAMEERR=1, BREAKINT=1, single RX_VALID. Then ERR_CLR -> BREAKINT=0.
- Glitch RXD low for 4 ticks in IDLE -> no RX_VALID, BUSY returns to 0.
- RX_READY=0: send 0x11 then 0x22 -> RX_DATA stays 0x11, OVERRUN=1. Assert PRESETn low mid-third-frame -> all outputs 0, no character after release.
